// File: rtl/fb_reader.sv
// Frame-buffer reader: walks a HDISP x VDISP frame over Wishbone classic reads,
// one outstanding request at a time, and streams pixels out through a small FIFO.
module fb_reader #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_en,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic [31:0] wshb_dat_sm,
  input  logic        wshb_ack,
  output logic [23:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          stb_q, stb_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [24:0]   fifo_mem_q [FIFO_DEPTH];

  logic          push;
  logic          pop;
  logic          room;
  logic          last_x;
  logic          last_y;
  logic          first_pix;
  logic [31:0]   pix_idx;
  logic          unused_dat_hi;

  // Only the slave's acknowledge of our own strobe counts; stray acks are dropped.
  assign push      = stb_q && wshb_ack;
  assign pop       = (count_q != '0) && pix_ready;
  // count < DEPTH keeps one slot free for the single read that may be in flight.
  assign room      = count_q < CW'(FIFO_DEPTH);
  assign last_x    = (x_q == X_LAST);
  assign last_y    = (y_q == Y_LAST);
  assign first_pix = (x_q == '0) && (y_q == '0);

  assign unused_dat_hi = ^wshb_dat_sm[31:24];

  // ---------------------------------------------------------------------------
  // Request FSM and pixel counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    state_d = state_q;
    stb_d   = stb_q;
    x_d     = x_q;
    y_d     = y_q;

    case (state_q)
      ST_IDLE: begin
        stb_d = 1'b0;
        if (frame_en) begin
          state_d = ST_RUN;
          stb_d   = room;
        end
      end

      ST_RUN: begin
        if (stb_q) begin
          if (wshb_ack) begin
            stb_d = 1'b0;
            if (last_x) begin
              x_d = '0;
              y_d = last_y ? '0 : y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
            if (last_x && last_y && !frame_en) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          stb_d = room;
        end
      end

      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stb_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead pixel FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // already mark every entry invalid, and a reset would stop RAM inference.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {first_pix, wshb_dat_sm[23:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pix_idx  = 32'(x_q) + 32'(y_q) * 32'(HDISP);
  assign wshb_adr = pix_idx << 2;

  assign wshb_stb = stb_q;
  assign wshb_cyc = stb_q;
  assign wshb_we  = 1'b0;
  assign wshb_sel = 4'b1111;
  assign wshb_cti = 3'b000;
  assign wshb_bte = 2'b00;

  assign pix_valid = (count_q != '0);
  assign pix_data  = fifo_mem_q[rd_ptr_q][23:0];
  assign pix_sof   = fifo_mem_q[rd_ptr_q][24];

endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader on a 4x2 frame: a Wishbone slave model feeds pixel data,
// a scoreboard queue carries expected pixels to the consumer side for comparison.
`timescale 1ns/1ps
module tb_fb_reader;

  localparam int HDISP = 4;
  localparam int VDISP = 2;
  localparam int DEPTH = 8;
  localparam int NPIX  = HDISP * VDISP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_en = 1'b0;
  logic        wshb_cyc, wshb_stb, wshb_we;
  logic [31:0] wshb_adr;
  logic [3:0]  wshb_sel;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic [31:0] wshb_dat_sm = 32'h0;
  logic        wshb_ack = 1'b0;
  logic [23:0] pix_data;
  logic        pix_sof, pix_valid;
  logic        pix_ready = 1'b0;

  always #5 clk = ~clk;

  fb_reader #(.HDISP(HDISP), .VDISP(VDISP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_en(frame_en),
    .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we),
    .wshb_adr(wshb_adr), .wshb_sel(wshb_sel), .wshb_cti(wshb_cti),
    .wshb_bte(wshb_bte), .wshb_dat_sm(wshb_dat_sm), .wshb_ack(wshb_ack),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and slave/consumer model state
  logic [24:0] sb[$];
  logic [24:0] exp_px;
  int exp_idx     = 0;
  int frame_no    = 0;
  int ack_total   = 0;
  int max_q       = 0;
  int last_hold   = 0;
  int wait_states = 0;
  int ready_mode  = 1;   // 0 stall, 1 always ready, 2 random, 3 single pop
  bit rand_delay  = 1'b0;
  bit data_ovr    = 1'b0;
  bit spurious    = 1'b0;
  bit busy        = 1'b0;
  bit acked_prev  = 1'b0;
  int cnt = 0, tgt = 0, hold = 0;

  function automatic logic [31:0] gen_data(input int idx, input int frm);
    if (data_ovr) return 32'hAB123456;
    return {8'(idx * 7 + frm) ^ 8'hE1, 8'(frm * 16 + idx), 8'(idx * 37 + 5), 8'(255 - idx - frm)};
  endfunction

  always @(negedge clk) begin
    check("pix_valid", pix_valid, sb.size() != 0);
    check("cyc_eq_stb", wshb_cyc, wshb_stb);
    if (acked_prev) check("stb_gap", wshb_stb, 1'b0);
    acked_prev = 1'b0;

    case (ready_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      2:       pix_ready = 1'($urandom_range(0, 1));
      default: begin pix_ready = 1'b1; ready_mode = 0; end
    endcase
    if (pix_valid && pix_ready) begin
      if (sb.size() == 0) begin
        check("underflow", 1, 0);
      end else begin
        exp_px = sb.pop_front();
        check("pix_data", pix_data, exp_px[23:0]);
        check("pix_sof", pix_sof, exp_px[24]);
      end
    end

    if (wshb_stb) begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = 0;
        hold = 0;
        tgt  = rand_delay ? int'($urandom_range(0, 3)) : wait_states;
      end
      hold++;
      check("adr", wshb_adr, exp_idx * 4);
      if (cnt == tgt) begin
        wshb_dat_sm = gen_data(exp_idx, frame_no);
        wshb_ack    = 1'b1;
        sb.push_back({exp_idx == 0, wshb_dat_sm[23:0]});
        busy       = 1'b0;
        acked_prev = 1'b1;
        last_hold  = hold;
        ack_total++;
        exp_idx = (exp_idx + 1) % NPIX;
        if (exp_idx == 0) frame_no++;
      end else begin
        wshb_ack    = 1'b0;
        wshb_dat_sm = 32'hDEADBEEF;
        cnt++;
      end
    end else begin
      busy        = 1'b0;
      wshb_ack    = spurious;
      wshb_dat_sm = 32'h00FFFFFF;
    end
    if (sb.size() > max_q) max_q = sb.size();
  end

  task automatic wait_acks(input int target, input int budget);
    for (int i = 0; i < budget && ack_total < target; i++) begin
      @(posedge clk); #1;
    end
    if (ack_total < target) check("ack_timeout", ack_total, target);
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 12; i++) begin
      @(posedge clk); #1;
      if (!wshb_stb && sb.size() == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 12) check("idle_timeout", quiet, 12);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    wshb_ack   = 1'b0;
    sb.delete();
    exp_idx    = 0;
    busy       = 1'b0;
    acked_prev = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset state
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", wshb_stb, 1'b0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_adr", wshb_adr, 32'h0);
    check("we", wshb_we, 1'b0);
    check("sel", wshb_sel, 4'hF);
    check("cti", wshb_cti, 3'h0);
    check("bte", wshb_bte, 2'h0);
    #1 rst_n = 1'b1;

    // Zero-wait slave, always ready: first-request latency, two frames of addresses
    base = ack_total;
    @(negedge clk);
    frame_en = 1'b1;
    @(posedge clk); #1;
    check("first_stb", wshb_stb, 1'b1);
    check("first_adr", wshb_adr, 32'h0);
    wait_acks(base + NPIX + 1, 200);
    frame_en = 1'b0;
    wait_idle(300);
    check("two_frames_acks", ack_total - base, 2 * NPIX);

    // Stalled consumer fills FIFO; stray acks while stb is low must be ignored
    base = ack_total;
    ready_mode = 0;
    spurious   = 1'b1;
    frame_en   = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("full_acks", ack_total - base, DEPTH);
    check("full_valid", pix_valid, 1'b1);
    check("full_stb", wshb_stb, 1'b0);
    ready_mode = 3;
    repeat (20) @(posedge clk);
    #1;
    check("one_pop_acks", ack_total - base, DEPTH + 1);
    check("one_pop_stb", wshb_stb, 1'b0);
    spurious   = 1'b0;
    frame_en   = 1'b0;
    ready_mode = 1;
    wait_idle(300);
    check("stall_phase_acks", ack_total - base, 2 * NPIX);

    // Three wait states, upper data byte discarded
    base = ack_total;
    wait_states = 3;
    data_ovr    = 1'b1;
    frame_en    = 1'b1;
    @(posedge clk); #1;
    frame_en = 1'b0;
    wait_acks(base + 1, 50);
    check("wait_hold", last_hold, 4);
    check("wait_pix_data", pix_data, 24'h123456);
    wait_idle(300);
    check("wait_frame_acks", ack_total - base, NPIX);
    data_ovr    = 1'b0;
    wait_states = 0;

    // frame_en dropped mid-frame: frame completes, then restarts at address 0
    base = ack_total;
    frame_en = 1'b1;
    wait_acks(base + 4, 100);
    frame_en = 1'b0;
    wait_idle(300);
    check("drop_acks", ack_total - base, NPIX);
    check("drop_model_idx", exp_idx, 0);
    check("drop_stb", wshb_stb, 1'b0);
    @(negedge clk);
    frame_en = 1'b1;
    @(posedge clk); #1;
    check("restart_stb", wshb_stb, 1'b1);
    check("restart_adr", wshb_adr, 32'h0);
    frame_en = 1'b0;
    wait_idle(300);

    // Asynchronous reset with a request open and five pixels buffered
    base = ack_total;
    wait_states = 2;
    ready_mode  = 0;
    frame_en    = 1'b1;
    for (int i = 0; i < 200 && !((ack_total - base) == 5 && wshb_stb); i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_acks", ack_total - base, 5);
    check("pre_rst_valid", pix_valid, 1'b1);
    #1 do_reset();
    #1;
    check("async_rst_stb", wshb_stb, 1'b0);
    check("async_rst_valid", pix_valid, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_stb", wshb_stb, 1'b1);
    check("post_rst_adr", wshb_adr, 32'h0);
    ready_mode = 1;
    frame_en   = 1'b0;
    wait_idle(400);
    wait_states = 0;

    // Random ready and random ack delays over three frames
    base = ack_total;
    max_q = 0;
    ready_mode = 2;
    rand_delay = 1'b1;
    frame_en   = 1'b1;
    wait_acks(base + 2 * NPIX, 3000);
    frame_en = 1'b0;
    wait_idle(3000);
    check("rand_acks", ack_total - base, 3 * NPIX);
    check("rand_no_overflow", max_q <= DEPTH, 1'b1);
    check("rand_model_idx", exp_idx, 0);
    rand_delay = 1'b0;
    ready_mode = 1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
